data_memory_unit: RTL and testbench

Parametrised, clocked data-memory stage that replaces the combinational byte/word memory in the memory stage. Accepts one load/store request per handshake from the EX/MEM boundary, supports byte, half-word and word accesses (little-endian) with optional sign extension, flags misaligned or out-of-range accesses, and models a configurable access latency. While an access is in flight it back-pressures the pipeline through `req_ready`.

---
 rtl/data_memory_unit.sv | 165 ++++++++++++++++
 tb/tb_data_memory_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_unit.sv
// rtl/data_memory_unit.sv - clocked byte-addressed data memory with configurable latency
// Accepts one load/store per handshake, checks size/alignment/range and answers after LATENCY edges.
module data_memory_unit #(
  parameter int    DEPTH_BYTES = 1024,
  parameter int    LATENCY     = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_fire, w_fire_nxt;
  logic            w_accept;

  logic            r_write, r_signed;
  logic [1:0]      r_size;
  logic [31:0]     r_addr, r_wdata;

  logic            r_resp_valid, r_resp_error;
  logic [31:0]     r_resp_rdata;

  logic [7:0]      r_mem [DEPTH_BYTES];

  logic [2:0]      w_nbytes;
  logic [32:0]     w_last;
  logic            w_err;
  logic [AW-1:0]   w_a0, w_a1, w_a2, w_a3;
  logic [7:0]      w_b0, w_b1, w_b2, w_b3;
  logic [31:0]     w_rdata;

  assign req_ready  = (r_state == S_IDLE);
  assign w_accept   = req_valid && req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_error = r_resp_error;

  // r_fire marks the final edge of an access: commit/read happens there while req_ready is already high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_fire  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fire  <= w_fire_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fire_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (LATENCY > 1) begin
            w_state_nxt = S_BUSY;
            w_cnt_nxt   = CW'(LATENCY - 1);
          end else begin
            w_fire_nxt  = 1'b1;
          end
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = S_IDLE;
          w_fire_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= 2'b00;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
    end else if (w_accept) begin
      r_write  <= req_write;
      r_signed <= req_signed;
      r_size   <= req_size;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
    end
  end

  // range check is done in 33 bits so addresses near 2^32 cannot wrap into range
  always_comb begin
    w_nbytes = (r_size == 2'b00) ? 3'd1 : (r_size == 2'b01) ? 3'd2 : 3'd4;
    w_last   = {1'b0, r_addr} + {30'd0, w_nbytes} - 33'd1;
    w_err    = (r_size == 2'b11)
            || ((r_size == 2'b01) && r_addr[0])
            || ((r_size == 2'b10) && (r_addr[1:0] != 2'b00))
            || (w_last >= 33'(DEPTH_BYTES));
  end

  assign w_a0 = r_addr[AW-1:0];
  assign w_a1 = w_a0 + AW'(1);
  assign w_a2 = w_a0 + AW'(2);
  assign w_a3 = w_a0 + AW'(3);
  assign w_b0 = r_mem[w_a0];
  assign w_b1 = r_mem[w_a1];
  assign w_b2 = r_mem[w_a2];
  assign w_b3 = r_mem[w_a3];

  always_comb begin
    w_rdata = 32'd0;
    if (!w_err && !r_write) begin
      case (r_size)
        2'b00:   w_rdata = {{24{r_signed & w_b0[7]}}, w_b0};
        2'b01:   w_rdata = {{16{r_signed & w_b1[7]}}, w_b1, w_b0};
        default: w_rdata = {w_b3, w_b2, w_b1, w_b0};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_error <= 1'b0;
    end else begin
      r_resp_valid <= r_fire;
      if (r_fire) begin
        r_resp_rdata <= w_rdata;
        r_resp_error <= w_err;
      end
    end
  end

  // array is deliberately outside reset; an aborted access never reaches r_fire
  always_ff @(posedge clk) begin
    if (r_fire && r_write && !w_err) begin
      r_mem[w_a0] <= r_wdata[7:0];
      if (r_size != 2'b00) r_mem[w_a1] <= r_wdata[15:8];
      if (r_size == 2'b10) begin
        r_mem[w_a2] <= r_wdata[23:16];
        r_mem[w_a3] <= r_wdata[31:24];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// tb/tb_data_memory_unit.sv - self-checking bench for data_memory_unit
// Instance 0 runs with LATENCY=1, instance 1 with LATENCY=4; both share one reference model.
module tb_data_memory_unit;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [1:0]  req_size   [2];
  logic        req_signed [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_error [2];

  always #5 clk = ~clk;

  data_memory_unit #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
    .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0])
  );

  data_memory_unit #(.DEPTH_BYTES(DEPTH), .LATENCY(4)) u_dut_l4 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
    .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit [7:0] ref_mem [2][DEPTH];

  typedef struct {
    bit        w;
    bit [1:0]  sz;
    bit        sg;
    bit [31:0] a;
    bit [31:0] wd;
    bit [31:0] exp_rd;
    bit        exp_er;
    string     name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no handshake within 20 cycles, required one", name);
  endtask

  // Reference: bytes in a plain array, loads assembled and sign-extended arithmetically
  task automatic model(input int d, input bit w, input bit [1:0] sz, input bit sg,
                       input bit [31:0] a, input bit [31:0] wd,
                       output bit [31:0] rd, output bit er);
    int     n;
    longint last;
    longint val;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    last = longint'({32'd0, a}) + n - 1;
    er   = (sz == 2'd3) || ((a % n) != 0) || (last >= DEPTH);
    rd   = 32'd0;
    if (!er) begin
      if (w) begin
        for (int i = 0; i < n; i++) ref_mem[d][a + i] = wd[8*i +: 8];
      end else begin
        val = 0;
        for (int i = 0; i < n; i++) val += longint'(ref_mem[d][a + i]) << (8 * i);
        if (sg && (val >= (longint'(1) << (8 * n - 1)))) val -= longint'(1) << (8 * n);
        rd = val[31:0];
      end
    end
  endtask

  task automatic do_req(input int d, input bit w, input bit [1:0] sz, input bit sg,
                        input bit [31:0] a, input bit [31:0] wd,
                        output logic [31:0] rd, output logic er);
    bit rdy;
    int n;
    req_write[d]  = w;
    req_size[d]   = sz;
    req_signed[d] = sg;
    req_addr[d]   = a;
    req_wdata[d]  = wd;
    req_valid[d]  = 1'b1;
    rdy = 1'b0;
    n   = 0;
    while (!rdy && n < 20) begin
      @(negedge clk);
      rdy = req_ready[d];
      @(posedge clk);
      #1;
      n++;
    end
    req_valid[d] = 1'b0;
    rd = 'x;
    er = 'x;
    if (!rdy) begin
      note_timeout("accept_timeout");
      return;
    end
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (resp_valid[d]) break;
    end
    if (!resp_valid[d]) begin
      note_timeout("resp_timeout");
      return;
    end
    check("latency", n, (d == 0) ? 1 : 4);
    rd = resp_rdata[d];
    er = resp_error[d];
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    bit   [31:0] m_rd;
    bit          m_er;
    bit          saw;

    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, "st_w_010"});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0, "ld_w_010"});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h013, 32'h0,        32'hFFFFFFDE, 1'b0, "ld_bs_013"});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h013, 32'h0,        32'h000000DE, 1'b0, "ld_bu_013"});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h012, 32'h0,        32'hFFFFDEAD, 1'b0, "ld_hs_012"});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h010, 32'h0,        32'hFFFFBEEF, 1'b0, "ld_hs_010"});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h010, 32'h0,        32'h0000BEEF, 1'b0, "ld_hu_010"});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h020, 32'h11223344, 32'h00000000, 1'b0, "st_w_020"});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h011, 32'h0,        32'h00000000, 1'b1, "ld_w_mis"});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h021, 32'h0000AAAA, 32'h00000000, 1'b1, "st_h_mis"});
    vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h020, 32'h0,        32'h00000000, 1'b1, "ld_sz3"});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h020, 32'h0,        32'h11223344, 1'b0, "ld_w_020"});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h3FE, 32'hCAFEF00D, 32'h00000000, 1'b1, "st_w_3fe"});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0,        32'h00000000, 1'b0, "ld_w_3fc0"});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h3FC, 32'h12345678, 32'h00000000, 1'b0, "st_w_3fc"});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0,        32'h12345678, 1'b0, "ld_w_3fc"});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h3FE, 32'h0,        32'h00001234, 1'b0, "ld_hu_3fe"});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h3FF, 32'h0,        32'h00000012, 1'b0, "ld_bs_3ff"});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h3FF, 32'h0,        32'h00000000, 1'b1, "ld_h_3ff"});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h400, 32'h0,        32'h00000000, 1'b1, "ld_b_400"});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0,   32'h00000000, 1'b1, "ld_w_wrap"});

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 2'd0;
      req_signed[d] = 1'b0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", req_ready[d], 1);
      check("rst_resp_valid", resp_valid[d], 0);
      check("rst_rdata", resp_rdata[d], 0);
      check("rst_error", resp_error[d], 0);
      rst_n[d] = 1'b1;
    end
    @(posedge clk);
    #1;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH / 4; i++) begin
        model(d, 1'b1, 2'd2, 1'b0, 32'(i * 4), 32'd0, m_rd, m_er);
        do_req(d, 1'b1, 2'd2, 1'b0, 32'(i * 4), 32'd0, rd, er);
      end

    for (int d = 0; d < 2; d++)
      foreach (vecs[i]) begin
        model(d, vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd, m_rd, m_er);
        do_req(d, vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd, rd, er);
        check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
        check({vecs[i].name, "_error"}, er, vecs[i].exp_er);
      end

    // LATENCY=1: store then load on consecutive edges, one response per cycle
    req_write[0] = 1'b1; req_size[0] = 2'd2; req_signed[0] = 1'b0;
    req_addr[0] = 32'h40; req_wdata[0] = 32'h0BADCAFE; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_write[0] = 1'b0;
    @(posedge clk); #1;
    check("b2b_st_valid", resp_valid[0], 1);
    check("b2b_st_rdata", resp_rdata[0], 0);
    check("b2b_st_error", resp_error[0], 0);
    check("b2b_ready", req_ready[0], 1);
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    check("b2b_ld_valid", resp_valid[0], 1);
    check("b2b_ld_rdata", resp_rdata[0], 32'h0BADCAFE);
    @(posedge clk); #1;
    check("b2b_idle_valid", resp_valid[0], 0);
    check("b2b_hold_rdata", resp_rdata[0], 32'h0BADCAFE);
    model(0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h0BADCAFE, m_rd, m_er);

    // LATENCY=4: back-pressure window and a second request held across it
    req_write[1] = 1'b0; req_size[1] = 2'd2; req_signed[1] = 1'b0;
    req_addr[1] = 32'h10; req_valid[1] = 1'b1;
    @(negedge clk);
    check("l4_ready_idle", req_ready[1], 1);
    @(posedge clk); #1;
    req_addr[1] = 32'h20;
    for (int i = 0; i < 3; i++) begin
      check("l4_ready_busy", req_ready[1], 0);
      check("l4_no_resp", resp_valid[1], 0);
      @(posedge clk); #1;
    end
    check("l4_ready_last", req_ready[1], 1);
    check("l4_no_resp_last", resp_valid[1], 0);
    @(posedge clk); #1;
    check("l4_resp_a_valid", resp_valid[1], 1);
    check("l4_resp_a_rdata", resp_rdata[1], 32'hDEADBEEF);
    check("l4_b_accepted", req_ready[1], 0);
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    check("l4_pulse_end", resp_valid[1], 0);
    check("l4_rdata_held", resp_rdata[1], 32'hDEADBEEF);
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    check("l4_resp_b_valid", resp_valid[1], 1);
    check("l4_resp_b_rdata", resp_rdata[1], 32'h11223344);

    // LATENCY=4: reset in the middle of a store aborts it
    req_write[1] = 1'b1; req_size[1] = 2'd2; req_addr[1] = 32'h10;
    req_wdata[1] = 32'h55AA55AA; req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    #2;
    check("abort_ready", req_ready[1], 1);
    check("abort_valid", resp_valid[1], 0);
    check("abort_rdata", resp_rdata[1], 0);
    check("abort_error", resp_error[1], 0);
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (resp_valid[1]) saw = 1'b1;
    end
    check("abort_no_resp", saw, 0);
    do_req(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, er);
    check("abort_mem_kept", rd, 32'hDEADBEEF);

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 150; i++) begin
        bit        w, sg;
        bit [1:0]  sz;
        bit [31:0] a, wd;
        int        r;
        w  = 1'($urandom_range(0, 1));
        sg = 1'($urandom_range(0, 1));
        r  = $urandom_range(0, 9);
        sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        a  = $urandom_range(0, DEPTH - 1);
        if ($urandom_range(0, 3) != 0) a = a & ~32'((sz == 2'd0) ? 0 : (sz == 2'd1) ? 1 : 3);
        if ($urandom_range(0, 15) == 0) a = $urandom;
        wd = $urandom;
        model(d, w, sz, sg, a, wd, m_rd, m_er);
        do_req(d, w, sz, sg, a, wd, rd, er);
        check("rand_rdata", rd, m_rd);
        check("rand_error", er, m_er);
      end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
